// File: rtl/cp0_irq_if.sv
// CP0 request/response bus between the EXE-stage controller and cp0_irq.
// Carries CP operation, register access and the PC redirect outputs.
interface cp0_irq_if;
    logic        en;
    logic [1:0]  oper;
    logic [4:0]  addr_r;
    logic [31:0] data_r;
    logic [4:0]  addr_w;
    logic [31:0] data_w;
    logic [31:0] pc_resume;
    logic        ir_en;
    logic        jump_en;
    logic [31:0] jump_addr;

    modport master (
        output en, oper, addr_r, addr_w, data_w, pc_resume, ir_en,
        input  data_r, jump_en, jump_addr
    );

    modport slave (
        input  en, oper, addr_r, addr_w, data_w, pc_resume, ir_en,
        output data_r, jump_en, jump_addr
    );
endinterface

// File: rtl/cp0_irq.sv
// Coprocessor-0 registers and single-level interrupt take/service control.
// Define CP0_IRQ_SYNC_EN to pass ir_in through a 2-flop synchronizer.
module cp0_irq #(
    parameter logic [31:0] HANDLER_RST = 32'h0000_0008
) (
    input  logic     clk,
    input  logic     rst,
    cp0_irq_if.slave bus,
    input  logic     ir_in,
    output logic     in_service
);
    localparam logic [1:0] OP_MTC0 = 2'b10;
    localparam logic [1:0] OP_ERET = 2'b11;

    typedef enum logic {IDLE, SERVICE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        ie;
    logic        pending;
    logic [31:0] epc;
    logic [31:0] hbase;
    logic        req;
    logic        req_q;
    logic        rise;
    logic        eret;
    logic        take;
    logic        wr;

`ifdef CP0_IRQ_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= 2'b00;
        else     sync <= {sync[0], ir_in};
    end

    assign req = sync[1];
`else
    assign req = ir_in;
`endif

    assign rise = req & ~req_q;
    assign wr   = bus.en && (bus.oper == OP_MTC0);
    assign eret = !rst && bus.en && (bus.oper == OP_ERET);
    assign take = !rst && (state == IDLE) && pending && ie
                  && bus.ir_en && bus.en && (bus.oper != OP_ERET);

    assign bus.jump_en   = eret | take;
    assign bus.jump_addr = eret ? epc : hbase;
    assign in_service    = (state == SERVICE);

    always_comb begin
        state_nxt = state;
        if (eret)      state_nxt = IDLE;
        else if (take) state_nxt = SERVICE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Take overrides a same-cycle MTC0 to STATUS/EPC, so it is applied last
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q   <= 1'b0;
            pending <= 1'b0;
            ie      <= 1'b0;
            epc     <= 32'h0;
            hbase   <= HANDLER_RST;
        end else begin
            req_q   <= req;
            pending <= take ? rise : (pending | rise);
            if (wr && bus.addr_w == 5'd12) ie    <= bus.data_w[0];
            if (wr && bus.addr_w == 5'd14) epc   <= bus.data_w;
            if (wr && bus.addr_w == 5'd15) hbase <= bus.data_w;
            if (take) begin
                epc <= bus.pc_resume;
                ie  <= 1'b0;
            end
            if (eret) ie <= 1'b1;
        end
    end

    always_comb begin
        bus.data_r = 32'h0;
        case (bus.addr_r)
            5'd12:   bus.data_r = {31'h0, ie};
            5'd13:   bus.data_r = {30'h0, in_service, pending};
            5'd14:   bus.data_r = epc;
            5'd15:   bus.data_r = hbase;
            default: bus.data_r = 32'h0;
        endcase
    end
endmodule

// File: doc/cp0_irq.md
# cp0_irq

Coprocessor-0 and interrupt unit for the 5-stage pipelined MIPS CPU. It sits beside the EXE stage and executes the controller's `cp_oper` requests: MFC0 reads, MTC0 writes and ERET. It latches external interrupt requests and drives `jump_en`/`jump_addr` into the PC path. `jump_en` also makes the controller flush the ID stage. It owns STATUS, CAUSE, EPC and the handler-base register, and runs a small take/service state machine so nested interrupts are held off.

## Interface
- `HANDLER_RST`, 32'h0000_0008, reset value of the handler-base register
- `clk`  input  1  main clock; all state updates on rising edge
- `rst`  input  1  asynchronous, active-high reset
- `en`  input  1  EXE stage enable; when 0, no register write, take, or ERET occurs
- `oper`  input  2  CP operation: 2'b00 NONE, 2'b01 MFC0, 2'b10 MTC0, 2'b11 ERET
- `addr_r`  input  5  CP0 register read address (rd field, MFC0)
- `data_r`  output  32  CP0 read data, combinational from `addr_r`
- `addr_w`  input  5  CP0 register write address (rd field, MTC0)
- `data_w`  input  32  MTC0 write data (forwarded rt value)
- `pc_resume`  input  32  PC to resume at after an interrupt (oldest unexecuted instruction)
- `ir_en`  input  1  controller permits an interrupt take this cycle
- `ir_in`  input  1  external interrupt request, asynchronous level
- `jump_en`  output  1  redirect PC this cycle
- `jump_addr`  output  32  redirect target
- `in_service`  output  1  a handler is running (state SERVICE)

## Operation
- **Register map:**
  - 12 STATUS: bit0 IE, read/write; other bits read 0.
  - 13 CAUSE: bit0 pending, bit1 in_service; read-only, writes ignored.
  - 14 EPC: read/write.
  - 15 HBASE: handler base, read/write.
  - All other addresses read 32'h0 and ignore writes.
- **Request edge:** a rising edge of the (conditioned) request sets `pending`. `pending` is cleared only on a take. An edge in the same cycle as a take stays set.
- **States:**
  - IDLE → SERVICE on a take.
  - SERVICE → IDLE on an ERET with `en`.
  - An ERET in IDLE also jumps to EPC and stays in IDLE.
- **Take condition:** state IDLE && `pending` && IE && `ir_en` && `en` && `oper`≠ERET.
- **Effects of a take:**
  - `jump_en`=1, `jump_addr`=HBASE.
  - On the clock edge: EPC←`pc_resume`, IE←0, `pending`←0, state←SERVICE.
- **Effects of an ERET:**
  - `jump_en`=1, `jump_addr`=EPC.
  - On the clock edge: IE←1, state←IDLE.
- **Priority:** ERET beats a take in the same cycle. A take's IE←0 beats an MTC0 to STATUS in the same cycle. A take's EPC update beats an MTC0 to EPC.
- **MTC0:** writes `data_w` to `addr_w` at the clock edge when `en`=1.
- **MFC0:** `data_r` is always driven. A read of the register being written in the same cycle returns the old value.

## Timing
- **Reset values:**
  - IE=0, EPC=0, HBASE=`HANDLER_RST`, `pending`=0, state IDLE.
  - Synchronizer/edge flops reset to 0.
  - `jump_en`=0, `in_service`=0.
- **`jump_en`/`jump_addr`:** combinational, zero latency. They are valid in the same cycle as the ERET or take decision, so the controller flushes ID in that cycle.
- **Request latency:** `ir_in` rise to `pending`=1 is 3 cycles with synchronizer, 1 cycle without.
- **Hold-off:** in SERVICE, new edges set `pending` but are not taken. A pending request is taken on the first eligible cycle after ERET re-enters IDLE, at the earliest the cycle after ERET.
- **`en`=0 (stall):** freezes EPC, STATUS, HBASE and state. `pending` still captures edges.
- **Reset mid-service:** returns to IDLE with IE=0; any pending request is discarded.

## Configuration
- `CP0_IRQ_SYNC_EN` defined: `ir_in` passes a 2-flop synchronizer before the edge-detect flop.
- `CP0_IRQ_SYNC_EN` undefined: `ir_in` feeds the edge-detect flop directly; `ir_in` must already be synchronous to `clk`.

## Test plan
- **Reset and readback:** assert `rst`, then read regs 12/13/14/15 → 0, 0, 0, 32'h8. `jump_en`=0.
- **MTC0 then MFC0:** MTC0 reg 15 ← 32'h0000_0100, MTC0 reg 12 ← 1, then MFC0 12/15 → 1, 32'h100. A write to 13 leaves CAUSE unchanged.
- **Take:** IE=1, `ir_en`=1, pulse `ir_in` with `pc_resume`=32'h40 (sync on).
  - 3 cycles later `jump_en`=1 with `jump_addr`=32'h100.
  - Next cycle EPC=32'h40, IE=0, `in_service`=1.
- **Nested hold-off:** second `ir_in` pulse during SERVICE → CAUSE bit0=1, no jump. ERET → `jump_addr`=32'h40. The following cycle a take occurs to 32'h100.
- **Gating:** `ir_en`=0 or `en`=0 while pending with IE=1 → no jump until both are 1. ERET and an eligible take in the same cycle → `jump_addr`=EPC, `pending` stays 1.
- **Async reset in SERVICE:** assert `rst` between clock edges → `in_service`=0, IE=0, `jump_en`=0 immediately.
